// File: rtl/icnbc_pkg.sv
// Shared types and width helpers for the icnbc codebook decoder.
package icnbc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StResp
  } state_e;

  function automatic int unsigned idx_width(int unsigned d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic int unsigned cnt_width(int unsigned d);
    return $clog2(d + 1);
  endfunction

  // One above the largest possible distance, so the first entry always wins.
  function automatic int unsigned dist_sentinel(int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/icnbc_hdist.sv
// Combinational Hamming distance: XOR of two words followed by a popcount.
module icnbc_hdist #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] dist_o
);

  logic [N-1:0] diff;

  always_comb begin
    diff   = a_i ^ b_i;
    dist_o = '0;
    for (int i = 0; i < N; i++) begin
      dist_o = dist_o + N'(diff[i]);
    end
  end

endmodule

// File: rtl/icnbc_decoder.sv
// Codebook capture plus sequential minimum-Hamming-distance decoder.
// Optional build macro: ICNBC_DEC_TIE_DETECT_EN (tie flag, forces full scans).
module icnbc_decoder
  import icnbc_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned depth = 256,
  parameter int unsigned width = N,
  localparam int unsigned IW   = idx_width(depth),
  localparam int unsigned CW   = cnt_width(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load_valid,
  input  logic [N-1:0]  load_code,
  output logic          load_ready,
  input  logic          q_valid,
  input  logic [N-1:0]  q_word,
  output logic          q_ready,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [IW-1:0] r_index,
  output logic [N-1:0]  r_dist,
  output logic          r_tie,
  output logic          r_miss,
  output logic [CW-1:0] count
);

  localparam int unsigned DW = N + 1;
  localparam logic [CW-1:0] Full = CW'(depth);
  localparam logic [DW-1:0] DistInit = DW'(dist_sentinel(N));

  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  word_q, word_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic [DW-1:0] min_dist_q, min_dist_d;
  logic [IW-1:0] min_idx_q, min_idx_d;
  logic          tie_q, tie_d;
  logic          miss_q, miss_d;

  logic [width-1:0] mem [depth];
  logic [width-1:0] mem_q;
  logic             mem_vld_q;
  logic [CW-1:0]    mem_idx_q;
  logic             mem_we, mem_re;
  logic             load_fire, q_fire;
  logic [N-1:0]     hd_dist;

  icnbc_hdist #(
    .N(N)
  ) u_hdist (
    .a_i    (word_q),
    .b_i    (mem_q[N-1:0]),
    .dist_o (hd_dist)
  );

  assign load_ready = !rst && (state_q == StIdle) && (count_q != Full);
  assign q_ready    = !rst && (state_q == StIdle);
  assign load_fire  = load_valid && load_ready;
  assign q_fire     = q_valid && q_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_d     = word_q;
    rd_idx_d   = rd_idx_q;
    min_dist_d = min_dist_q;
    min_idx_d  = min_idx_q;
    tie_d      = tie_q;
    miss_d     = miss_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_q)
      StIdle: begin
        if (clr) begin
          count_d = '0;
        end else if (load_fire) begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
        // Query sees the post-load/post-clear count of this same cycle.
        if (q_fire) begin
          word_d     = q_word;
          rd_idx_d   = '0;
          min_dist_d = DistInit;
          min_idx_d  = '0;
          tie_d      = 1'b0;
          miss_d     = (count_d == '0);
          if (count_d == '0) begin
            min_dist_d = DW'(N);
            state_d    = StResp;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (rd_idx_q < count_q) begin
          mem_re   = 1'b1;
          rd_idx_d = rd_idx_q + CW'(1);
        end
        if (mem_vld_q) begin
          if (DW'(hd_dist) < min_dist_q) begin
            min_dist_d = DW'(hd_dist);
            min_idx_d  = mem_idx_q[IW-1:0];
            tie_d      = 1'b0;
          end
`ifdef ICNBC_DEC_TIE_DETECT_EN
          else if (DW'(hd_dist) == min_dist_q) begin
            tie_d = 1'b1;
          end
          if (mem_idx_q == count_q - CW'(1)) begin
            state_d = StResp;
          end
`else
          if ((hd_dist == '0) || (mem_idx_q == count_q - CW'(1))) begin
            state_d = StResp;
          end
`endif
        end
      end
      StResp: begin
        if (r_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      word_q     <= '0;
      rd_idx_q   <= '0;
      min_dist_q <= '0;
      min_idx_q  <= '0;
      tie_q      <= 1'b0;
      miss_q     <= 1'b0;
      mem_vld_q  <= 1'b0;
      mem_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_q     <= word_d;
      rd_idx_q   <= rd_idx_d;
      min_dist_q <= min_dist_d;
      min_idx_q  <= min_idx_d;
      tie_q      <= tie_d;
      miss_q     <= miss_d;
      mem_vld_q  <= mem_re;
      if (mem_re) begin
        mem_idx_q <= rd_idx_q;
      end
    end
  end

  // Single-port codebook: writes only in IDLE, reads only in SCAN.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[count_q[IW-1:0]] <= load_code;
    end else if (mem_re) begin
      mem_q <= mem[rd_idx_q[IW-1:0]];
    end
  end

  assign r_valid = (state_q == StResp);
  assign r_index = r_valid ? min_idx_q : '0;
  assign r_dist  = r_valid ? min_dist_q[N-1:0] : '0;
  assign r_tie   = r_valid && tie_q;
  assign r_miss  = r_valid && miss_q;
  assign count   = count_q;

endmodule

// File: tb/tb_icnbc_decoder.sv
// Directed self-checking bench for icnbc_decoder (N=8, depth=256).
module tb_icnbc_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_code = '0;
  logic       load_ready;
  logic       q_valid = 1'b0;
  logic [7:0] q_word = '0;
  logic       q_ready;
  logic       r_valid;
  logic       r_ready = 1'b0;
  logic [7:0] r_index;
  logic [7:0] r_dist;
  logic       r_tie;
  logic       r_miss;
  logic [8:0] count;

  int checks = 0;
  int failures = 0;

`ifdef ICNBC_DEC_TIE_DETECT_EN
  localparam bit TieEn = 1'b1;
`else
  localparam bit TieEn = 1'b0;
`endif

  always #5 clk = ~clk;

  icnbc_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load_valid (load_valid),
    .load_code  (load_code),
    .load_ready (load_ready),
    .q_valid    (q_valid),
    .q_word     (q_word),
    .q_ready    (q_ready),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_index    (r_index),
    .r_dist     (r_dist),
    .r_tie      (r_tie),
    .r_miss     (r_miss),
    .count      (count)
  );

  task automatic load_words(input logic [7:0] words[$]);
    foreach (words[i]) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_code  = words[i];
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // lat = edge count from acceptance to the first edge that samples r_valid high.
  task automatic run_query(input logic [7:0] w, output int lat);
    @(negedge clk);
    q_valid = 1'b1;
    q_word  = w;
    @(negedge clk);
    q_valid = 1'b0;
    lat = -1;
    for (int j = 0; j < 400; j++) begin
      if (r_valid) begin
        lat = j + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (load_ready !== 1'b0 || q_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: load_ready=%b q_ready=%b required 0 0", load_ready, q_ready);
    end
    checks++;
    if ({r_valid, r_index, r_dist, r_tie, r_miss, count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: v=%b idx=%0d dist=%0d tie=%b miss=%b count=%0d required all 0",
               r_valid, r_index, r_dist, r_tie, r_miss, count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1 || q_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: load_ready=%b q_ready=%b required 1 1", load_ready, q_ready);
    end
  endtask

  task automatic test_empty();
    int lat;
    run_query(8'hA5, lat);
    checks++;
    if (lat !== 1 || r_miss !== 1'b1 || r_index !== 8'd0 || r_dist !== 8'd8 || r_tie !== 1'b0) begin
      failures++;
      $display("FAIL empty_query: lat=%0d miss=%b idx=%0d dist=%0d tie=%b required 1 1 0 8 0",
               lat, r_miss, r_index, r_dist, r_tie);
    end
    consume();
  endtask

  task automatic test_match();
    int lat;
    load_words('{8'h00, 8'h0F, 8'hF0, 8'hFF});
    checks++;
    if (count !== 9'd4) begin
      failures++;
      $display("FAIL load_count: count=%0d required 4", count);
    end
    run_query(8'h0E, lat);
    checks++;
    if (lat !== 6 || r_index !== 8'd1 || r_dist !== 8'd1 || r_tie !== 1'b0 || r_miss !== 1'b0) begin
      failures++;
      $display("FAIL match_0e: lat=%0d idx=%0d dist=%0d tie=%b miss=%b required 6 1 1 0 0",
               lat, r_index, r_dist, r_tie, r_miss);
    end
    consume();
  endtask

  task automatic test_tie();
    int lat;
    run_query(8'h3C, lat);
    checks++;
    if (lat !== 6 || r_index !== 8'd0 || r_dist !== 8'd4 || r_tie !== TieEn || r_miss !== 1'b0) begin
      failures++;
      $display("FAIL tie_3c: lat=%0d idx=%0d dist=%0d tie=%b miss=%b required 6 0 4 %b 0",
               lat, r_index, r_dist, r_tie, r_miss, TieEn);
    end
    consume();
  endtask

  task automatic test_early_exit();
    int lat;
    int exp_lat;
    exp_lat = TieEn ? 6 : 4;
    run_query(8'h0F, lat);
    checks++;
    if (lat !== exp_lat || r_index !== 8'd1 || r_dist !== 8'd0 || r_tie !== 1'b0) begin
      failures++;
      $display("FAIL exact_0f: lat=%0d idx=%0d dist=%0d tie=%b required %0d 1 0 0",
               lat, r_index, r_dist, r_tie, exp_lat);
    end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    int bad = 0;
    run_query(8'hF1, lat);  // F1: dist 1 to F0 (idx 2), 3 to FF
    for (int c = 0; c < 5; c++) begin
      if (r_valid !== 1'b1 || r_index !== 8'd2 || r_dist !== 8'd1 || q_ready !== 1'b0 ||
          load_ready !== 1'b0) begin
        bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_stable: unstable_cycles=%0d required 0", bad);
    end
    consume();
    checks++;
    if (r_valid !== 1'b0 || q_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: r_valid=%b q_ready=%b required 0 1", r_valid, q_ready);
    end
  endtask

  task automatic test_same_cycle();
    int lat;
    // clr wins over a same-cycle load.
    @(negedge clk);
    clr = 1'b1;
    load_valid = 1'b1;
    load_code = 8'h11;
    @(negedge clk);
    clr = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (count !== 9'd0) begin
      failures++;
      $display("FAIL clr_priority: count=%0d required 0", count);
    end
    // Load and query together: the query must see the new entry.
    load_valid = 1'b1;
    load_code  = 8'h55;
    q_valid    = 1'b1;
    q_word     = 8'h54;
    @(negedge clk);
    load_valid = 1'b0;
    q_valid    = 1'b0;
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      if (r_valid) begin
        lat = j + 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat !== 3 || r_miss !== 1'b0 || r_index !== 8'd0 || r_dist !== 8'd1 || count !== 9'd1) begin
      failures++;
      $display("FAIL load_and_query: lat=%0d miss=%b idx=%0d dist=%0d count=%0d required 3 0 0 1 1",
               lat, r_miss, r_index, r_dist, count);
    end
    consume();
  endtask

  task automatic test_full();
    int lat;
    do_clear();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_code  = 8'(i);
    end
    @(negedge clk);
    load_code = 8'hAA;  // held source; must not be taken
    checks++;
    if (count !== 9'd256 || load_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_count: count=%0d load_ready=%b required 256 0", count, load_ready);
    end
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (count !== 9'd256) begin
      failures++;
      $display("FAIL full_no_wrap: count=%0d required 256", count);
    end
    run_query(8'h00, lat);
    checks++;
    if (lat < 0 || r_index !== 8'd0 || r_dist !== 8'd0) begin
      failures++;
      $display("FAIL full_entry0: lat=%0d idx=%0d dist=%0d required idx 0 dist 0",
               lat, r_index, r_dist);
    end
    consume();
    run_query(8'hFF, lat);
    checks++;
    if (lat < 0 || r_index !== 8'd255 || r_dist !== 8'd0 || r_tie !== 1'b0) begin
      failures++;
      $display("FAIL full_entry255: lat=%0d idx=%0d dist=%0d tie=%b required idx 255 dist 0 tie 0",
               lat, r_index, r_dist, r_tie);
    end
    consume();
    do_clear();
    checks++;
    if (count !== 9'd0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_clear: count=%0d load_ready=%b required 0 1", count, load_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_code  = 8'(i);
    end
    @(negedge clk);
    load_valid = 1'b0;
    q_valid = 1'b1;
    q_word  = 8'h80;
    @(negedge clk);
    q_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b0 || q_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready_low: load_ready=%b q_ready=%b required 0 0", load_ready, q_ready);
    end
    @(negedge clk);
    checks++;
    if ({r_valid, r_index, r_dist, r_tie, r_miss, count} !== '0) begin
      failures++;
      $display("FAIL rst_mid_scan: v=%b idx=%0d dist=%0d tie=%b miss=%b count=%0d required all 0",
               r_valid, r_index, r_dist, r_tie, r_miss, count);
    end
    rst = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (r_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || q_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_no_response: r_valid_cycles=%0d q_ready=%b required 0 1", seen, q_ready);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_match();
    test_tie();
    test_early_exit();
    test_hold();
    test_same_cycle();
    test_full();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icnbc_decoder.md
# icnbc_decoder

Receive-side companion to the `icnbc` codeword generator. It captures the generated codebook streamed out of `icnbc` into a local memory. It then decodes received N-bit words by sequentially scanning the codebook for the entry with minimum Hamming distance, returning that entry's index, the distance, and an ambiguity flag. It sits after the framing/sync-detect path of the unambiguous-encapsulation receiver.

## Interface
- `N`, 8, codeword width in bits
- `depth`, 256, codebook capacity in entries; `IW = $clog2(depth)`, `CW = $clog2(depth+1)`
- `width`, N, codebook memory word width; must equal N
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  empty the codebook; honoured in IDLE only
- `load_valid`  in  1  codeword present on `load_code`
- `load_code`  in  N  codeword from `icnbc` `codes`
- `load_ready`  out  1  high in IDLE while count < depth
- `q_valid`  in  1  received word present
- `q_word`  in  N  received word
- `q_ready`  out  1  high in IDLE
- `r_valid`  out  1  result valid; held until `r_ready`
- `r_ready`  in  1  result consumed
- `r_index`  out  IW  index of best-matching entry
- `r_dist`  out  N  Hamming distance to that entry (0..N)
- `r_tie`  out  1  another entry has equal minimum distance
- `r_miss`  out  1  codebook empty at query time
- `count`  out  CW  entries currently loaded

## Operation
- States: IDLE, SCAN, RESP.
- IDLE:
  - `load_valid && load_ready` writes `load_code` to mem[count], then count+1.
  - `clr` zeroes count; `clr` has priority over a same-cycle load.
  - `q_valid && q_ready` latches `q_word` and goes to SCAN.
  - A same-cycle load and query are both accepted. The load lands first, so the query sees the new entry.
- SCAN:
  - Entries i = 0..count-1 are read one per cycle, each XORed with the latched word, with a popcount via `icnbc_hdist`.
  - A running minimum (dist, index) is kept. Update occurs only on strictly smaller distance, so the lowest index wins ties.
  - Initial minimum is dist N+1, index 0.
  - Leaves to RESP after the last entry's distance is compared.
  - If count==0, SCAN is skipped: IDLE goes directly to RESP with `r_miss`=1, `r_index`=0, `r_dist`=N.
- RESP: `r_valid`=1; outputs stable. `r_valid && r_ready` returns to IDLE.
- `load_ready`, `q_ready` are low outside IDLE. Loads presented then are not taken, and sources must hold.
- Full: count==depth forces `load_ready`=0; count never wraps.
- Early exit: `r_dist` reaching 0 ends SCAN immediately unless tie detection is compiled in.
- `rst` in any state: IDLE, count=0, all outputs 0. A scan in flight is discarded and no response is issued.

## Timing
- Memory read is registered (1-cycle read latency).
- Query accepted at edge T, count=K>0, no early exit: `r_valid` rises at T+K+2.
- Empty codebook: `r_valid` at T+1.
- Earliest next query acceptance is the cycle after the `r_valid && r_ready` handshake.
- Load throughput is 1 entry/cycle; `count` updates at the edge after acceptance.
- Reset values: `load_ready`=0 during rst and 1 the first cycle after, `q_ready` same, and `r_valid`, `r_index`, `r_dist`, `r_tie`, `r_miss`, `count` all 0.

## Configuration
- `ICNBC_DEC_TIE_DETECT_EN` defined:
  - `r_tie`=1 when ≥2 entries share the minimum distance.
  - A full scan is always performed (no early exit).
- Not defined:
  - `r_tie` is tied to 0.
  - Early exit on distance 0 is enabled.

## Structure
- `icnbc_pkg`: state enum (IDLE/SCAN/RESP), width helper functions for IW/CW, and the sentinel constant for the initial minimum.
- Sub-module `icnbc_hdist`: combinational XOR + popcount, parameter N, output N bits.
- Codebook is an inferred single-port RAM in the top; write in IDLE, read in SCAN.

## Test plan
- Load 8'h00, 8'h0F, 8'hF0, 8'hFF; query 8'h0E -> `r_index`=1, `r_dist`=1, `r_tie`=0, `r_miss`=0, `r_valid` at T+6 (macro on).
- Same codebook, query 8'h3C -> dist 4 to all four entries -> `r_index`=0, `r_dist`=4, `r_tie`=1 with macro, 0 without.
- Empty codebook, query 8'hA5 -> `r_valid` at T+1, `r_miss`=1, `r_index`=0, `r_dist`=8.
- Load 256 entries with `load_valid` held high -> count=256, `load_ready` drops, 257th word not written. `clr` -> count=0.
- Hold `r_ready`=0 for 5 cycles -> outputs stable and `q_ready`=0 throughout. Then assert `r_ready` -> IDLE next cycle.
- Assert `rst` mid-SCAN with K=100 -> next cycle all outputs 0, count=0, and no `r_valid` ever issued for that query.
